// File: rtl/queue_pkg.sv
// Shared constants, pointer-wrap helper and operation encoding for the queue block.
package queue_pkg;

    localparam int unsigned DEFAULT_DEPTH     = 8;
    localparam int unsigned DEFAULT_BANDWIDTH = 4;

    // Push/pop request encoding, formed as {pop, push}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

    // Wrapped increment; the compare makes it correct for non power-of-2 depths.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/queue_if.sv
// Push/pop bus of the queue; optional almost flags under QUEUE_ALMOST_FLAGS_EN.
interface queue_if
    import queue_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned BANDWIDTH = DEFAULT_BANDWIDTH
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [BANDWIDTH-1:0] data_in;
    logic                 push;
    logic                 pop;
    logic                 err_clr;
    logic [BANDWIDTH-1:0] data_out;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;
    logic                 overflow;
    logic                 underflow;
`ifdef QUEUE_ALMOST_FLAGS_EN
    logic                 almost_full;
    logic                 almost_empty;
`endif

    modport master (
        output data_in, push, pop, err_clr,
        input  data_out, full, empty, count, overflow, underflow
`ifdef QUEUE_ALMOST_FLAGS_EN
        , input almost_full, almost_empty
`endif
    );

    modport slave (
        input  data_in, push, pop, err_clr,
        output data_out, full, empty, count, overflow, underflow
`ifdef QUEUE_ALMOST_FLAGS_EN
        , output almost_full, almost_empty
`endif
    );

endinterface

// File: rtl/queue_ptr.sv
// Wrapping pointer register (0..DEPTH-1), used for both head and tail.
module queue_ptr
    import queue_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);
    localparam int unsigned PW = $clog2(DEPTH);

    // Advance by one on inc, wrapping to 0 after DEPTH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= PW'(ptr_next(32'(ptr), DEPTH));
        end
    end

endmodule

// File: rtl/queue.sv
// Circular FIFO with simultaneous push/pop, occupancy count and sticky error flags.
// Optional almost_full/almost_empty outputs are enabled by defining QUEUE_ALMOST_FLAGS_EN.
module queue
    import queue_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned BANDWIDTH = DEFAULT_BANDWIDTH
`ifdef QUEUE_ALMOST_FLAGS_EN
    ,
    parameter int unsigned ALMOST_FULL_TH  = DEPTH - 2,
    parameter int unsigned ALMOST_EMPTY_TH = 2
`endif
) (
    input logic    clk,
    input logic    rst,
    queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [BANDWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [CW-1:0]        count_q;
    logic [BANDWIDTH-1:0] data_out_q;
    logic                 overflow_q;
    logic                 underflow_q;
    logic                 is_full;
    logic                 is_empty;
    op_e                  op;
    logic                 do_push;
    logic                 do_pop;
    logic                 ovf_set;
    logic                 unf_set;

    assign is_full  = (count_q == CW'(DEPTH));
    assign is_empty = (count_q == '0);
    assign op       = op_e'({bus.pop, bus.push});

    // Decide which requests are performed and which raise an error.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (op)
            OP_PUSH: begin
                do_push = ~is_full;
                ovf_set = is_full;
            end
            OP_POP: begin
                do_pop  = ~is_empty;
                unf_set = is_empty;
            end
            OP_BOTH: begin
                // A pop frees the slot the push needs, so full still accepts both.
                do_push = 1'b1;
                do_pop  = ~is_empty;
                unf_set = is_empty;
            end
            default: ;
        endcase
    end

    queue_ptr #(.DEPTH(DEPTH)) u_head (.clk(clk), .rst(rst), .inc(do_pop),  .ptr(head));
    queue_ptr #(.DEPTH(DEPTH)) u_tail (.clk(clk), .rst(rst), .inc(do_push), .ptr(tail));

    // Storage write; contents are left untouched by reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= bus.data_in;
        end
    end

    // Occupancy tracking; push+pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (do_push && !do_pop) begin
            count_q <= count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_q <= count_q - CW'(1);
        end
    end

    // Registered read data and sticky error flags (a new error beats err_clr).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (do_pop) begin
                data_out_q <= mem[head];
            end
            overflow_q  <= ovf_set | (overflow_q  & ~bus.err_clr);
            underflow_q <= unf_set | (underflow_q & ~bus.err_clr);
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.count     = count_q;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

`ifdef QUEUE_ALMOST_FLAGS_EN
    assign bus.almost_full  = (32'(count_q) >= ALMOST_FULL_TH);
    assign bus.almost_empty = (32'(count_q) <= ALMOST_EMPTY_TH);
`endif

endmodule

// File: tb/tb_queue.sv
// Self-checking bench for queue: directed scenarios plus randomized traffic
// against a queue-based reference model. Two instances: DEPTH=8 and DEPTH=5.
module tb_queue;
    import queue_pkg::*;

    localparam int unsigned BW = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    queue_if #(.DEPTH(8), .BANDWIDTH(BW)) q8 ();
    queue_if #(.DEPTH(5), .BANDWIDTH(BW)) q5 ();

    queue #(.DEPTH(8), .BANDWIDTH(BW)) dut8 (.clk(clk), .rst(rst), .bus(q8.slave));
    queue #(.DEPTH(5), .BANDWIDTH(BW)) dut5 (.clk(clk), .rst(rst), .bus(q5.slave));

    // Reference model state
    logic [BW-1:0] m8[$];
    logic [BW-1:0] out8;
    bit            ovf8, unf8;
    logic [BW-1:0] m5[$];
    logic [BW-1:0] out5;

    task automatic model_clear();
        m8.delete(); out8 = '0; ovf8 = 0; unf8 = 0;
        m5.delete(); out5 = '0;
    endtask

    // Drive one cycle on the DEPTH=8 instance and advance the model.
    task automatic step8(input bit pu, input bit po, input logic [BW-1:0] din, input bit clr);
        bit o_set;
        bit u_set;
        o_set = 0;
        u_set = 0;
        q8.push = pu; q8.pop = po; q8.data_in = din; q8.err_clr = clr;
        @(posedge clk);
        if (pu && po) begin
            if (m8.size() == 0) begin
                m8.push_back(din);
                u_set = 1;
            end else begin
                out8 = m8.pop_front();
                m8.push_back(din);
            end
        end else if (pu) begin
            if (m8.size() < 8) m8.push_back(din);
            else o_set = 1;
        end else if (po) begin
            if (m8.size() > 0) out8 = m8.pop_front();
            else u_set = 1;
        end
        ovf8 = o_set | (ovf8 & !clr);
        unf8 = u_set | (unf8 & !clr);
        #1;
        q8.push = 0; q8.pop = 0; q8.err_clr = 0;
    endtask

    // Drive one cycle on the DEPTH=5 instance (no error scenarios used there).
    task automatic step5(input bit pu, input bit po, input logic [BW-1:0] din);
        q5.push = pu; q5.pop = po; q5.data_in = din; q5.err_clr = 0;
        @(posedge clk);
        if (po && m5.size() > 0) out5 = m5.pop_front();
        if (pu && (m5.size() < 5 || po)) m5.push_back(din);
        #1;
        q5.push = 0; q5.pop = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        model_clear();
        checks++; if (q8.count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", q8.count); end
        checks++; if (q8.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", q8.empty); end
        checks++; if (q8.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", q8.full); end
        checks++; if (q8.data_out !== 4'd0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", q8.data_out); end
        checks++; if ({q8.overflow, q8.underflow} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {q8.overflow, q8.underflow}); end
        checks++; if (q5.empty !== 1'b1) begin failures++; $display("FAIL reset_empty5 got=%b exp=1", q5.empty); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fifo_order();
        for (int i = 1; i <= 3; i++) step8(1, 0, BW'(i), 0);
        checks++; if (q8.count !== 4'd3) begin failures++; $display("FAIL order_count got=%0d exp=3", q8.count); end
        for (int i = 1; i <= 3; i++) begin
            step8(0, 1, '0, 0);
            checks++; if (q8.data_out !== BW'(i)) begin failures++; $display("FAIL order_data got=%h exp=%h", q8.data_out, BW'(i)); end
            checks++; if (q8.count !== 4'(3 - i)) begin failures++; $display("FAIL order_count got=%0d exp=%0d", q8.count, 3 - i); end
        end
        checks++; if (q8.empty !== 1'b1) begin failures++; $display("FAIL order_empty got=%b exp=1", q8.empty); end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 8; i++) step8(1, 0, BW'(i), 0);
        checks++; if (q8.full !== 1'b1 || q8.count !== 4'd8) begin failures++; $display("FAIL full_state got=%b/%0d exp=1/8", q8.full, q8.count); end
        checks++; if (q8.overflow !== 1'b0) begin failures++; $display("FAIL full_no_ovf got=%b exp=0", q8.overflow); end
        step8(1, 0, 4'hF, 0);
        checks++; if (q8.overflow !== 1'b1) begin failures++; $display("FAIL overflow got=%b exp=1", q8.overflow); end
        checks++; if (q8.count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", q8.count); end
        for (int i = 0; i < 8; i++) begin
            step8(0, 1, '0, 0);
            checks++; if (q8.data_out !== BW'(i)) begin failures++; $display("FAIL drain_data got=%h exp=%h", q8.data_out, BW'(i)); end
        end
        checks++; if (q8.empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", q8.empty); end
    endtask

    task automatic test_full_push_pop();
        step8(0, 0, '0, 1);
        checks++; if (q8.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", q8.overflow); end
        for (int i = 0; i < 8; i++) step8(1, 0, BW'(i), 0);
        step8(1, 1, 4'hA, 0);
        checks++; if (q8.data_out !== 4'h0) begin failures++; $display("FAIL both_full_data got=%h exp=0", q8.data_out); end
        checks++; if (q8.count !== 4'd8 || q8.overflow !== 1'b0) begin failures++; $display("FAIL both_full_state got=%0d/%b exp=8/0", q8.count, q8.overflow); end
        for (int i = 0; i < 8; i++) step8(0, 1, '0, 0);
        checks++; if (q8.data_out !== 4'hA) begin failures++; $display("FAIL both_full_last got=%h exp=a", q8.data_out); end
    endtask

    task automatic test_underflow();
        step8(0, 1, '0, 0);
        checks++; if (q8.underflow !== 1'b1) begin failures++; $display("FAIL underflow got=%b exp=1", q8.underflow); end
        checks++; if (q8.data_out !== 4'hA) begin failures++; $display("FAIL unf_hold got=%h exp=a", q8.data_out); end
        step8(0, 0, '0, 1);
        checks++; if (q8.underflow !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", q8.underflow); end
        step8(0, 1, '0, 1);
        checks++; if (q8.underflow !== 1'b1) begin failures++; $display("FAIL set_wins got=%b exp=1", q8.underflow); end
        step8(0, 0, '0, 1);
        step8(1, 1, 4'h5, 0);
        checks++; if (q8.count !== 4'd1 || q8.underflow !== 1'b1) begin failures++; $display("FAIL both_empty got=%0d/%b exp=1/1", q8.count, q8.underflow); end
        checks++; if (q8.data_out !== 4'hA) begin failures++; $display("FAIL no_bypass got=%h exp=a", q8.data_out); end
        step8(0, 1, '0, 0);
        checks++; if (q8.data_out !== 4'h5 || q8.empty !== 1'b1) begin failures++; $display("FAIL both_empty_pop got=%h/%b exp=5/1", q8.data_out, q8.empty); end
        step8(0, 0, '0, 1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) step5(1, 0, 4'($urandom));
        for (int i = 0; i < 12; i++) begin
            step5(1, 1, 4'($urandom));
            checks++; if (q5.data_out !== out5) begin failures++; $display("FAIL wrap_data got=%h exp=%h", q5.data_out, out5); end
            checks++; if (q5.count !== 4'(m5.size())) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", q5.count, m5.size()); end
        end
        for (int i = 0; i < 3; i++) begin
            step5(0, 1, '0);
            checks++; if (q5.data_out !== out5) begin failures++; $display("FAIL wrap_drain got=%h exp=%h", q5.data_out, out5); end
        end
        checks++; if (q5.empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", q5.empty); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int unsigned bias;
            bias = ((i / 50) % 2 == 0) ? 75 : 25;
            step8($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 10,
                  4'($urandom), $urandom_range(0, 15) == 0);
            checks++; if (q8.count !== 4'(m8.size())) begin failures++; $display("FAIL rnd_count got=%0d exp=%0d", q8.count, m8.size()); end
            checks++; if (q8.data_out !== out8) begin failures++; $display("FAIL rnd_data got=%h exp=%h", q8.data_out, out8); end
            checks++; if (q8.full !== (m8.size() == 8) || q8.empty !== (m8.size() == 0)) begin failures++; $display("FAIL rnd_full_empty got=%b%b size=%0d", q8.full, q8.empty, m8.size()); end
            checks++; if (q8.overflow !== ovf8 || q8.underflow !== unf8) begin failures++; $display("FAIL rnd_flags got=%b%b exp=%b%b", q8.overflow, q8.underflow, ovf8, unf8); end
`ifdef QUEUE_ALMOST_FLAGS_EN
            checks++; if (q8.almost_full !== (m8.size() >= 6) || q8.almost_empty !== (m8.size() <= 2)) begin failures++; $display("FAIL rnd_almost got=%b%b size=%0d", q8.almost_full, q8.almost_empty, m8.size()); end
`endif
        end
    endtask

    task automatic test_async_reset();
        rst = 1'b1;
        @(negedge clk);
        model_clear();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) step8(1, 0, BW'(i), 0);
        step8(0, 1, '0, 0);
        checks++; if (q8.count !== 4'd4 || q8.data_out !== 4'd1) begin failures++; $display("FAIL pre_rst got=%0d/%h exp=4/1", q8.count, q8.data_out); end
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        checks++; if (q8.count !== 4'd0 || q8.empty !== 1'b1) begin failures++; $display("FAIL async_rst_count got=%0d/%b exp=0/1", q8.count, q8.empty); end
        checks++; if (q8.data_out !== 4'd0) begin failures++; $display("FAIL async_rst_data got=%h exp=0", q8.data_out); end
        @(negedge clk);
        rst = 1'b0;
        step8(0, 1, '0, 0);
        checks++; if (q8.underflow !== 1'b1 || q8.data_out !== 4'd0) begin failures++; $display("FAIL post_rst_empty got=%b/%h exp=1/0", q8.underflow, q8.data_out); end
    endtask

    initial begin
        rst = 1'b1;
        q8.push = 0; q8.pop = 0; q8.data_in = '0; q8.err_clr = 0;
        q5.push = 0; q5.pop = 0; q5.data_in = '0; q5.err_clr = 0;
        test_reset();
        test_fifo_order();
        test_full_overflow();
        test_full_push_pop();
        test_underflow();
        test_wrap();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/queue.md
Name: queue

Overview:
- Circular FIFO buffer that is the other-end counterpart of the team's LIFO stack.
- Data enters at the tail and is removed from the head, so words leave in arrival order.
- Uses the same push/pop/full/empty interface style as the stack, so the two can be swapped in datapaths that need FIFO instead of LIFO ordering.
- Adds simultaneous push+pop, an occupancy count and sticky overflow/underflow error flags.

Parameters:
- DEPTH, 8, number of entries; any integer >= 2 (not restricted to a power of 2).
- BANDWIDTH, 4, data word width in bits.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  BANDWIDTH  word to enqueue.
- push  input  1  enqueue request, sampled at the rising edge of clk.
- pop  input  1  dequeue request, sampled at the rising edge of clk.
- data_out  output  BANDWIDTH  registered; the last dequeued word.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set by a rejected push.
- underflow  output  1  sticky; set by a rejected pop.
- err_clr  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset (any time, including mid-operation):
  - head, tail and count go to 0.
  - data_out, overflow and underflow go to 0.
  - Memory contents need not be cleared.
  - On release, empty=1 and full=0.
- Pointers:
  - head and tail are in 0..DEPTH-1.
  - Each increments and wraps to 0 after DEPTH-1 by explicit compare, not by natural overflow.
- full and empty are combinational from count.
- Per rising edge of clk (rst low), case by push/pop:
  - push only, not full: mem[tail] <= data_in; tail advances; count+1.
  - push only, full: nothing stored; overflow <= 1.
  - pop only, not empty: data_out <= mem[head]; head advances; count-1.
  - pop only, empty: data_out holds; underflow <= 1.
  - push and pop, not empty (full included): both are performed. data_out <= mem[head] (the old value); mem[tail] <= data_in; both pointers advance; count unchanged. A full queue therefore accepts a push when a pop occurs in the same cycle.
  - push and pop, empty: the push is performed, the pop is rejected; underflow <= 1; count becomes 1; data_out holds. No bypass of data_in to data_out.
- Latency:
  - Popped data appears on data_out one edge after pop is sampled.
  - A pushed word can be popped at the earliest on the edge after the push edge.
- err_clr clears both sticky flags. If an error occurs in the same cycle as err_clr, the flag is set (set wins).
- count never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro: QUEUE_ALMOST_FLAGS_EN.
- When defined:
  - Adds parameter ALMOST_FULL_TH (default DEPTH-2) and ALMOST_EMPTY_TH (default 2).
  - Adds outputs almost_full (count >= ALMOST_FULL_TH) and almost_empty (count <= ALMOST_EMPTY_TH), both combinational from count.
  - Both outputs read 0 during reset... except almost_empty, which is 1 because count=0.
- When undefined: neither the ports nor the parameters exist, and all other behaviour is identical.

Decomposition:
- Package queue_pkg:
  - Default DEPTH and BANDWIDTH constants.
  - Function ptr_next(ptr, depth) returning the wrapped increment.
  - Typedef for the push/pop operation encoding: OP_IDLE, OP_PUSH, OP_POP, OP_BOTH.
- Sub-module queue_ptr: a wrapping pointer register with inc and rst inputs, instantiated twice (head and tail).
- Memory array, count and flags stay in queue.

Test Plan:
- Reset then push 1,2,3 -> pop three times: data_out = 1, 2, 3 on consecutive edges; count 3 -> 0; empty=1.
- Push 8 words 0..7 -> full=1, count=8. Ninth push of 0xF -> overflow=1, count stays 8. Then pop 8 -> data_out 0..7; no 0xF.
- Full queue, push=pop=1 with data_in=0xA -> data_out=0 (oldest), count=8. After draining, last word out = 0xA.
- Empty queue, pop -> underflow=1, data_out unchanged. Then err_clr -> flag 0. Empty queue with push+pop and data_in=5 -> count=1, underflow=1, and the next pop gives 5.
- Wrap test with DEPTH=5: 12 interleaved push/pop pairs -> output order matches input order across pointer wrap; count correct every cycle.
- Assert rst while count=4 -> count=0, empty=1, data_out=0 immediately, without waiting for clk.
